div_stream_ctrl: RTL and testbench
==================================

Name: div_stream_ctrl

Overview:
- Streaming control shell that sits directly around the pipelined unsigned divider.
- Upstream side: accepts signed or unsigned operand pairs over a valid/ready handshake and converts them to magnitudes.
- Drives the magnitudes into the divider and tracks each operation's metadata through a delay line matched to the divider latency.
- Downstream side: sign-corrects the divider result, substitutes divide-by-zero results and queues them in an output FIFO; a credit counter guarantees the non-stallable divider never overflows the FIFO.

Parameters:
- DATA_W, 32: operand/result width; must equal the divider's DATA_W.
- LATENCY, 4: divider register stages (DATA_W/OPERS_PER_STAGE); 0 is legal (combinational divider).
- FIFO_DEPTH, 8: output FIFO entries, power of two; must be >= LATENCY+2 for one op/cycle sustained throughput.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- in_signed  in  1  1 = two's-complement operation, 0 = unsigned
- in_dividend  in  DATA_W  dividend
- in_divisor  in  DATA_W  divisor
- div_dividend_o  out  DATA_W  magnitude dividend to the divider
- div_divisor_o  out  DATA_W  magnitude divisor to the divider
- div_quotient_i  in  DATA_W  divider quotient
- div_remainder_i  in  DATA_W  divider remainder
- out_valid  out  1  result available at FIFO head
- out_ready  in  1  consumer takes the result
- out_quotient  out  DATA_W  final quotient
- out_remainder  out  DATA_W  final remainder
- out_div_by_zero  out  1  divisor was zero

Behaviour:
- Accept when in_valid & in_ready at a rising edge; pop when out_valid & out_ready.
- Stage A register (loaded on accept): abs(dividend), abs(divisor) when in_signed, else raw values; plus metadata {valid, neg_q, neg_r, dbz, raw dividend}.
  - neg_q = signed & (sign bits differ).
  - neg_r = signed & dividend sign bit.
  - dbz = divisor == 0.
- Stage A drives div_*_o directly. When no accept occurs, stage A valid clears and operands hold their previous value.
- Metadata delay line: LATENCY registers, aligned with the divider output.
- Correction stage, combinational on the delay-line tail:
  - q = neg_q ? -div_quotient_i : div_quotient_i.
  - r = neg_r ? -div_remainder_i : div_remainder_i.
  - If dbz: q = all ones, r = raw dividend, flag = 1.
  - abs(MIN) is treated as 2^(DATA_W-1) unsigned, so MIN / -1 yields quotient MIN, remainder 0, with no special case.
- FIFO write happens on the edge where the tail valid is 1. The FIFO is show-ahead: out_* reflect the head entry and are stable while out_valid & !out_ready.
- Latency: an operation accepted in cycle c gives out_valid in cycle c+LATENCY+2 at the earliest. Results leave strictly in acceptance order.
- Credit counter occ (0..FIFO_DEPTH) counts in-flight operations plus FIFO entries:
  - +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
  - in_ready = (occ < FIFO_DEPTH), combinational from occ only, with no dependency on in_valid.
  - The FIFO therefore can never overflow. A write to a full FIFO is an assertion failure.
- FIFO full/empty:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Simultaneous read and write on a full FIFO is legal, since the pop frees the slot in the same cycle.
  - A read on an empty FIFO is impossible because out_valid = 0.
- Reset:
  - out_valid = 0, in_ready = 1, occ = 0, FIFO pointers = 0, stage A and delay-line valid bits = 0.
  - div_*_o, out_quotient, out_remainder and out_div_by_zero reset to 0.
  - Reset mid-operation discards all in-flight and queued results. Results the divider emits after reset are ignored because their valid bits are cleared.

Test Plan:
- Unsigned 100/7, single accept in cycle c (LATENCY=4) -> out_valid in cycle c+6, q=14, r=2, dbz=0; in_ready stays 1.
- Signed -7/2 (0xFFFFFFF9, 0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2 -> q=0xFFFFFFFD, r=1. Unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
- 5/0, signed and unsigned -> q=0xFFFFFFFF, r=5, dbz=1. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, dbz=0.
- Backpressure: out_ready=0, in_valid=1 with 10 distinct ops -> exactly 8 accepted, then in_ready=0. Raise out_ready -> all 10 results come out in order, with no loss or duplication.
- Throughput: out_ready=1, 100 back-to-back random ops -> in_ready never deasserts, one result per cycle, all match a reference model.
- Reset: assert rst for 1 cycle with 3 ops in flight and 2 queued -> out_valid=0 next cycle, no stale result ever appears, and a new op afterwards completes normally.

Source files
------------

// File: rtl/div_stream_ctrl_if.sv
// Stream and divider-side signals of div_stream_ctrl.
// slave is the controller view, master the environment view.
interface div_stream_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_signed;
  logic [DATA_W-1:0] in_dividend;
  logic [DATA_W-1:0] in_divisor;
  logic [DATA_W-1:0] div_dividend_o;
  logic [DATA_W-1:0] div_divisor_o;
  logic [DATA_W-1:0] div_quotient_i;
  logic [DATA_W-1:0] div_remainder_i;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_quotient;
  logic [DATA_W-1:0] out_remainder;
  logic              out_div_by_zero;

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor,
    input  div_quotient_i, div_remainder_i, out_ready,
    output in_ready, div_dividend_o, div_divisor_o,
    output out_valid, out_quotient, out_remainder,
    output out_div_by_zero
  );

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor,
    output div_quotient_i, div_remainder_i, out_ready,
    input  in_ready, div_dividend_o, div_divisor_o,
    input  out_valid, out_quotient, out_remainder,
    input  out_div_by_zero
  );
endinterface

// File: rtl/div_stream_ctrl.sv
// Stream shell around a fixed-latency unsigned divider:
// sign handling, metadata delay line, credit-guarded result FIFO.
module div_stream_ctrl #(
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  div_stream_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic              valid;
    logic              neg_q;
    logic              neg_r;
    logic              dbz;
    logic [DATA_W-1:0] raw;
  } meta_t;

  logic              accept;
  logic              pop;
  logic [PW-1:0]     occ;

  logic              dvd_neg;
  logic              dvs_neg;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;

  meta_t             a_meta;
  logic [DATA_W-1:0] a_dvd;
  logic [DATA_W-1:0] a_dvs;
  meta_t             tail;

  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] c_r;
  logic              c_z;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic              mem_z [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              wr;
  logic              full;
  logic              empty;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  // Credit gate: only occ decides readiness.
  assign bus.in_ready = occ < PW'(FIFO_DEPTH);

  assign dvd_neg = bus.in_signed & bus.in_dividend[DATA_W-1];
  assign dvs_neg = bus.in_signed & bus.in_divisor[DATA_W-1];
  assign dvd_mag = dvd_neg ? -bus.in_dividend : bus.in_dividend;
  assign dvs_mag = dvs_neg ? -bus.in_divisor : bus.in_divisor;

  // Credit counter: in-flight ops plus queued results.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else begin
      unique case (1'b1)
        accept & ~pop: occ <= occ + PW'(1);
        pop & ~accept: occ <= occ - PW'(1);
        default:       occ <= occ;
      endcase
    end
  end

  // Stage A: magnitudes to the divider plus op metadata.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_meta <= '0;
      a_dvd  <= '0;
      a_dvs  <= '0;
    end else begin
      a_meta.valid <= accept;
      if (accept) begin
        a_dvd        <= dvd_mag;
        a_dvs        <= dvs_mag;
        a_meta.neg_q <= dvd_neg ^ dvs_neg;
        a_meta.neg_r <= dvd_neg;
        a_meta.dbz   <= bus.in_divisor == '0;
        a_meta.raw   <= bus.in_dividend;
      end
    end
  end

  assign bus.div_dividend_o = a_dvd;
  assign bus.div_divisor_o  = a_dvs;

  generate
    if (LATENCY == 0) begin : g_nodly
      assign tail = a_meta;
    end else begin : g_dly
      meta_t dl [LATENCY];

      // Metadata shift line matched to the divider pipeline.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
        end else begin
          dl[0] <= a_meta;
          for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
        end
      end

      assign tail = dl[LATENCY-1];
    end
  endgenerate

  // Sign correction and divide-by-zero substitution.
  always_comb begin
    c_q = tail.neg_q ? -bus.div_quotient_i : bus.div_quotient_i;
    c_r = tail.neg_r ? -bus.div_remainder_i : bus.div_remainder_i;
    c_z = tail.dbz;
    if (tail.dbz) begin
      c_q = '1;
      c_r = tail.raw;
    end
  end

  assign wr    = tail.valid;
  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // Result FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
        mem_r[i] <= '0;
        mem_z[i] <= 1'b0;
      end
    end else begin
      if (wr) begin
        mem_q[wptr[AW-1:0]] <= c_q;
        mem_r[wptr[AW-1:0]] <= c_r;
        mem_z[wptr[AW-1:0]] <= c_z;
        wptr <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
    end
  end

  assign bus.out_valid       = ~empty;
  assign bus.out_quotient    = mem_q[rptr[AW-1:0]];
  assign bus.out_remainder   = mem_r[rptr[AW-1:0]];
  assign bus.out_div_by_zero = mem_z[rptr[AW-1:0]];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(wr && full && !pop)
  );
endmodule

// File: tb/tb_div_stream_ctrl.sv
// Scoreboard bench for div_stream_ctrl with a behavioural
// pipelined divider standing in for the real one.
module tb_div_stream_ctrl;
  localparam int W   = 32;
  localparam int LAT = 4;
  localparam int FD  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_stream_ctrl_if #(.DATA_W(W)) ifc ();

  div_stream_ctrl #(
    .DATA_W(W), .LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  // behavioural divider: LAT register stages, no reset
  logic [W-1:0] pq [LAT];
  logic [W-1:0] pr [LAT];
  always @(posedge clk) begin
    if (ifc.div_divisor_o == '0) begin
      pq[0] <= '1;
      pr[0] <= ifc.div_dividend_o;
    end else begin
      pq[0] <= ifc.div_dividend_o / ifc.div_divisor_o;
      pr[0] <= ifc.div_dividend_o % ifc.div_divisor_o;
    end
    for (int i = 1; i < LAT; i++) begin
      pq[i] <= pq[i-1];
      pr[i] <= pr[i-1];
    end
  end
  assign ifc.div_quotient_i  = pq[LAT-1];
  assign ifc.div_remainder_i = pr[LAT-1];

  int n_checks = 0;
  int n_pass   = 0;
  int accepts  = 0;
  int stalls   = 0;
  int cyc      = 0;
  int gaps     = 0;
  int last_pop = 0;
  bit tp_mode  = 0;
  bit tp_seen  = 0;

  logic [2*W:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [2*W:0] got,
                     input logic [2*W:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [2*W:0] mk(input logic [W-1:0] q,
                                      input logic [W-1:0] r,
                                      input logic z);
    return {q, r, z};
  endfunction

  function automatic logic [2*W:0] ref_div(input bit sgn,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [W-1:0] sa, sbv;
    if (b == '0) return mk('1, a, 1'b1);
    if (!sgn) return mk(a / b, a % b, 1'b0);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return mk(a, '0, 1'b0);
    sa  = a;
    sbv = b;
    return mk(sa / sbv, sa % sbv, 1'b0);
  endfunction

  // monitor: pop and compare whenever a result is taken
  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result",
            mk(ifc.out_quotient, ifc.out_remainder,
               ifc.out_div_by_zero), '1);
      end else begin
        chk("result",
            mk(ifc.out_quotient, ifc.out_remainder,
               ifc.out_div_by_zero), sb.pop_front());
      end
      if (tp_mode) begin
        if (tp_seen && cyc != last_pop + 1) gaps++;
        tp_seen  = 1;
        last_pop = cyc;
      end
    end
  end

  task automatic send(input bit sgn, input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic [2*W:0] exp);
    ifc.in_valid    = 1'b1;
    ifc.in_signed   = sgn;
    ifc.in_dividend = a;
    ifc.in_divisor  = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        sb.push_back(exp);
        accepts++;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        return;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++)
      @(negedge clk);
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    ifc.in_valid    = 1'b0;
    ifc.in_signed   = 1'b0;
    ifc.in_dividend = '0;
    ifc.in_divisor  = '0;
    ifc.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_q", ifc.out_quotient, 0);
    chk("rst_div_dvd", ifc.div_dividend_o, 0);
    @(posedge clk);
    #1;

    // single op latency: out_valid in c+6
    begin
      int k;
      send(0, 100, 7, mk(14, 2, 0));
      k = 0;
      for (int t = 1; t <= 20; t++) begin
        @(negedge clk);
        if (ifc.out_valid) begin
          k = t;
          break;
        end
      end
      chk("latency", k, LAT + 2);
      chk("in_ready_single", ifc.in_ready, 1);
      drain();
    end

    // directed sign and zero cases
    @(posedge clk);
    #1;
    send(1, 32'hFFFF_FFF9, 2,
         mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 0));
    send(1, 7, 32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 1, 0));
    send(0, 32'hFFFF_FFF9, 2, mk(32'h7FFF_FFFC, 1, 0));
    send(1, 5, 0, mk(32'hFFFF_FFFF, 5, 1));
    send(0, 5, 0, mk(32'hFFFF_FFFF, 5, 1));
    send(1, 32'h8000_0000, 32'hFFFF_FFFF,
         mk(32'h8000_0000, 0, 0));
    send(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, mk(3, 32'hFFFF_FFFF, 0));
    drain();

    // backpressure: 8 accepted, then in_ready low
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < FD; i++)
      send(0, 1000 + i, 3, mk((1000 + i) / 3, (1000 + i) % 3, 0));
    ifc.in_valid    = 1'b1;
    ifc.in_dividend = 2000;
    ifc.in_divisor  = 9;
    repeat (10) @(negedge clk);
    chk("bp_in_ready", ifc.in_ready, 0);
    chk("bp_accepts", accepts, FD);
    chk("bp_out_valid", ifc.out_valid, 1);
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b1;
    send(0, 2000, 9, mk(222, 2, 0));
    send(0, 2001, 9, mk(222, 3, 0));
    drain();

    // throughput: 100 back-to-back ops
    @(posedge clk);
    #1;
    stalls  = 0;
    gaps    = 0;
    tp_seen = 0;
    tp_mode = 1;
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] a, b;
      bit s;
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(1, 20)) : $urandom;
      if (i % 17 == 5) b = '0;
      if (i % 23 == 7) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      s = i[0];
      send(s, a, b, ref_div(s, a, b));
    end
    drain();
    tp_mode = 0;
    chk("tp_stalls", stalls, 0);
    chk("tp_gaps", gaps, 0);

    // reset with 2 queued and 3 in flight
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    send(0, 50, 5, mk(10, 0, 0));
    send(0, 51, 5, mk(10, 1, 0));
    repeat (8) @(posedge clk);
    #1;
    send(0, 52, 5, mk(10, 2, 0));
    send(0, 53, 5, mk(10, 3, 0));
    send(0, 54, 5, mk(10, 4, 0));
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", ifc.out_valid, 0);
    chk("post_rst_in_ready", ifc.in_ready, 1);
    ifc.out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", ifc.out_valid, 0);
    @(posedge clk);
    #1;
    send(0, 1000, 10, mk(100, 0, 0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
